// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage core: register index, hazard sequencer state
// and the load-use hazard predicate.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hazard_state_t;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(input logic memread, input regbits_t rd,
                                        input regbits_t rs, input regbits_t rt);
    return memread && (rd != 5'd0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register with saturating hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stage enables, bubble flushes, PC update and halt.
// Define HAZARD_PERF_EN to add saturating stall_cycles / flush_count counters.
module hazard_controller
  import cpu_types_pkg::*;
`ifdef HAZARD_PERF_EN
  #(parameter int STALL_CNT_W = 16)
`endif
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_redirect,
  input  logic       ihit,
  input  logic       dmem_req,
  input  logic       dhit,
  input  logic       wb_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] flush_count
`endif
);

  hazard_state_t r_state, w_state_nxt;
  logic          r_pend, w_pend_nxt;
  logic          r_rst_done;
  logic          w_load_use;
  logic [4:0]    w_en;
  logic          w_ifid_flush, w_idex_flush, w_halted;

  assign w_load_use = load_use_hit(ex_memread, ex_rd, id_rs, id_rt);

  // State, pending-redirect and reset-done registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= RUN;
      r_pend     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state: halt dominates; a redirect seen during a memory wait is deferred
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    if (!r_rst_done) begin
      w_state_nxt = RUN;
      w_pend_nxt  = 1'b0;
    end else if (wb_halt || (r_state == HALTED)) begin
      w_state_nxt = HALTED;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (dmem_req && !dhit) begin
            w_state_nxt = MEM_WAIT;
            w_pend_nxt  = ex_redirect;
          end else begin
            w_state_nxt = RUN;
            w_pend_nxt  = 1'b0;
          end
        end
        MEM_WAIT: begin
          if (dhit) begin
            w_state_nxt = RUN;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = MEM_WAIT;
            w_pend_nxt  = r_pend | ex_redirect;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Outputs: enables {pc, ifid, idex, exmem, memwb}, flushes and halt flag
  always_comb begin
    w_en         = 5'b00000;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halted     = 1'b0;
    if (!r_rst_done) begin
      w_halted = 1'b0;
    end else if (wb_halt || (r_state == HALTED)) begin
      w_halted = 1'b1;
    end else begin
      case (r_state)
        MEM_WAIT: begin
          if (dhit) begin
            w_en         = 5'b11111;
            w_ifid_flush = r_pend | ex_redirect;
            w_idex_flush = r_pend | ex_redirect;
          end else begin
            w_en = 5'b00000;
          end
        end
        RUN: begin
          if (dmem_req && !dhit) begin
            w_en = 5'b00000;
          end else if (ex_redirect) begin
            w_en         = 5'b11111;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (w_load_use || !ihit) begin
            w_en         = 5'b00111;
            w_idex_flush = 1'b1;
          end else begin
            w_en = 5'b11111;
          end
        end
        default: begin
          w_en = 5'b00000;
        end
      endcase
    end
  end

  assign pc_en      = w_en[4];
  assign ifid_en    = w_en[3];
  assign idex_en    = w_en[2];
  assign exmem_en   = w_en[1];
  assign memwb_en   = w_en[0];
  assign ifid_flush = w_ifid_flush;
  assign idex_flush = w_idex_flush;
  assign halted     = w_halted;

`ifdef HAZARD_PERF_EN
  logic w_stall_inc;
  assign w_stall_inc = r_rst_done && !w_en[4] && !w_halted;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(STALL_CNT_W)) u_flush_cnt (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_inc   (w_ifid_flush),
    .o_count (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed cases with literal
// expectations plus randomized traffic against a flag-based behavioural model.
module tb_hazard_controller;

  localparam int CW = 2;

  logic       CLK;
  logic       nRST;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       ex_memread, ex_redirect, ihit, dmem_req, dhit, wb_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, halted;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // model of the sequencing rules, kept as simple flags
  bit rst_done_m, halted_m, waiting_m, pend_m;
  int stall_m, flush_m;

  wire [7:0] got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};

`ifdef HAZARD_PERF_EN
  hazard_controller #(.STALL_CNT_W(CW)) dut (
`else
  hazard_controller dut (
`endif
    .CLK(CLK), .nRST(nRST), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_redirect(ex_redirect), .ihit(ihit),
    .dmem_req(dmem_req), .dhit(dhit), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush,halted}
  function automatic logic [7:0] model_out();
    logic f;
    logic lu;
    if (!rst_done_m) return 8'h00;
    if (halted_m || wb_halt) return 8'h01;
    if (waiting_m) begin
      if (!dhit) return 8'h00;
      f = pend_m | ex_redirect;
      return {5'b11111, f, f, 1'b0};
    end
    if (dmem_req && !dhit) return 8'h00;
    if (ex_redirect) return 8'hFE;
    lu = ex_memread && (ex_rd != 5'd0) && (ex_rd == id_rs || ex_rd == id_rt);
    if (lu || !ihit) return 8'h3A;
    return 8'hF8;
  endfunction

  task automatic model_step();
    if (!rst_done_m) begin
      rst_done_m = 1'b1;
    end else if (halted_m || wb_halt) begin
      halted_m = 1'b1; waiting_m = 1'b0; pend_m = 1'b0;
    end else if (waiting_m) begin
      if (dhit) begin
        waiting_m = 1'b0; pend_m = 1'b0;
      end else begin
        pend_m = pend_m | ex_redirect;
      end
    end else if (dmem_req && !dhit) begin
      waiting_m = 1'b1; pend_m = ex_redirect;
    end
  endtask

  // per-cycle comparison against the model, away from the rising edge
  always @(negedge CLK) begin : cmp
    logic [7:0] e;
    if (!nRST) begin
      rst_done_m = 1'b0; halted_m = 1'b0; waiting_m = 1'b0; pend_m = 1'b0;
      stall_m = 0; flush_m = 0;
      e = 8'h00;
    end else begin
      e = model_out();
    end
    chk("model_outputs", {24'd0, got}, {24'd0, e});
`ifdef HAZARD_PERF_EN
    chk("model_stall_cycles", {30'd0, stall_cycles}, stall_m);
    chk("model_flush_count", {30'd0, flush_count}, flush_m);
    if (nRST && rst_done_m) begin
      if (!e[7] && !e[0] && stall_m < (1 << CW) - 1) stall_m++;
      if (e[2] && flush_m < (1 << CW) - 1) flush_m++;
    end
`endif
    if (nRST) model_step();
  end

  task automatic idle();
    ex_memread = 1'b0; ex_redirect = 1'b0; ihit = 1'b1; dmem_req = 1'b0;
    dhit = 1'b0; wb_halt = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  task automatic step(input string nm, input logic [7:0] exp);
    @(negedge CLK);
    chk(nm, {24'd0, got}, {24'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    @(posedge CLK); #1;
    step("reset_state", 8'h00);
    nRST = 1'b1;
    step("before_rst_done", 8'h00);
    step("no_hazard", 8'hF8);

    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    step("load_use_bubble", 8'h3A);
    idle();
    step("after_load_use", 8'hF8);

    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    step("r0_no_hazard", 8'hF8);

    idle(); dmem_req = 1'b1; ex_redirect = 1'b1;
    step("mem_wait_1", 8'h00);
    ex_redirect = 1'b0;
    step("mem_wait_2", 8'h00);
    step("mem_wait_3", 8'h00);
    dhit = 1'b1;
    step("mem_hit_pending_flush", 8'hFE);
    idle();
    step("after_mem_wait", 8'hF8);

    ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
    step("redirect_over_load_use", 8'hFE);
    idle();

    dmem_req = 1'b1;
    step("halt_enter_wait", 8'h00);
    wb_halt = 1'b1;
    step("halt_in_mem_wait", 8'h01);
    wb_halt = 1'b0; dmem_req = 1'b0;
    step("halt_sticky_1", 8'h01);
    dhit = 1'b1;
    step("halt_sticky_2", 8'h01);
    idle(); nRST = 1'b0;
    step("halt_reset", 8'h00);
    nRST = 1'b1;
    step("halt_rst_done", 8'h00);
    step("halt_cleared", 8'hF8);

    dmem_req = 1'b1; ex_redirect = 1'b1;
    step("midstall_wait", 8'h00);
    ex_redirect = 1'b0; nRST = 1'b0;
    step("midstall_reset", 8'h00);
    nRST = 1'b1;
    step("midstall_rst_done", 8'h00);
    dhit = 1'b1;
    step("midstall_pend_dropped", 8'hF8);
    idle();

`ifdef HAZARD_PERF_EN
    nRST = 1'b0;
    step("perf_reset", 8'h00);
    nRST = 1'b1;
    step("perf_rst_done", 8'h00);
    ihit = 1'b0;
    for (int i = 0; i < 5; i++) step("perf_fetch_miss", 8'h3A);
    chk("stall_cycles_saturated", {30'd0, stall_cycles}, 32'd3);
    chk("flush_count_zero", {30'd0, flush_count}, 32'd0);
    idle(); ex_redirect = 1'b1;
    step("perf_redirect", 8'hFE);
    chk("flush_count_one", {30'd0, flush_count}, 32'd1);
    idle();
`endif

    for (int i = 0; i < 3000; i++) begin
      nRST        = ($urandom_range(0, 99) >= 2);
      ex_memread  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 99) < 15);
      ihit        = ($urandom_range(0, 99) < 80);
      dmem_req    = ($urandom_range(0, 99) < 30);
      dhit        = ($urandom_range(0, 99) < 50);
      wb_halt     = ($urandom_range(0, 99) < 1);
      @(posedge CLK); #1;
    end
    idle(); nRST = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
